// File: rtl/ram8_access_ctrl.sv
// ram8_access_ctrl: valid/ready request sequencer in front of an 8x4 RAM, with post-reset init sweep.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req_* / o_req_ready   : write/read request handshake (addr/data sampled at the accepting edge)
//   o_rsp_* / i_rsp_ready   : read response handshake
//   o_init_done             : high once every location has been written with INIT_VAL
//   o_ram_in/add/load       : RAM data, address and write-enable pins
//   i_ram_out               : RAM read data
module ram8_access_ctrl #(
    parameter int            DW        = 4,
    parameter int            AW        = 3,
    parameter logic [DW-1:0] INIT_VAL  = '0,
    parameter int            READ_WAIT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_data,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_init_done,
    output logic [DW-1:0] o_ram_in,
    output logic [AW-1:0] o_ram_add,
    output logic          o_ram_load,
    input  logic [DW-1:0] i_ram_out
);
    localparam logic [AW:0] CNT_END = (AW+1)'(1 << AW);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_RWAIT, S_RESP} state_t;
    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic [1:0]    r_wait;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_init_done;
    logic [DW-1:0] r_ram_in;
    logic [AW-1:0] r_ram_add;
    logic          r_ram_load;
    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_init_done = r_init_done;
    assign o_ram_in    = r_ram_in;
    assign o_ram_add   = r_ram_add;
    assign o_ram_load  = r_ram_load;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_init_done <= 1'b0;
            r_ram_in    <= '0;
            r_ram_add   <= '0;
            r_ram_load  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // counter runs one past the last address so the final load cycle is visible before exit
                    if (r_cnt == CNT_END) begin
                        r_ram_load  <= 1'b0;
                        r_ram_in    <= '0;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_ram_load <= 1'b1;
                        r_ram_add  <= r_cnt[AW-1:0];
                        r_ram_in   <= INIT_VAL;
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_ram_add   <= i_req_addr;
                        if (i_req_we) begin
                            r_ram_load <= 1'b1;
                            r_ram_in   <= i_req_data;
                            r_state    <= S_WRITE;
                        end else begin
                            r_ram_in <= '0;
                            r_wait   <= 2'(READ_WAIT);
                            r_state  <= S_RWAIT;
                        end
                    end
                end
                S_WRITE: begin
                    r_ram_load  <= 1'b0;
                    r_ram_in    <= '0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_RWAIT: begin
                    // address has been stable since the accept edge; sample once the wait count expires
                    if (r_wait == 2'd0) begin
                        r_rsp_data  <= i_ram_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule
